i2s_rx_master: RTL and testbench
================================

# i2s_rx_master

I2S master receiver for the keyword-spotting audio front end. Generates the word-select for a mono I2S microphone, deserialises its MSB-first data line into DATA_WIDTH-bit left-channel samples, and buffers them in a small FIFO. Samples are presented to the downstream feature-extraction stage over a valid/ready handshake. Sits directly downstream of the microphone, clocked by the same I2S bit clock.

## Interface
- DATA_WIDTH, 8 — sample width in bits.
- SLOT_BITS, 16 — bit clocks per channel slot. Power of two, ≥ DATA_WIDTH+1.
- FIFO_DEPTH, 4 — sample FIFO entries. Power of two, ≥ 2.

- i2s_clk  in  1  — I2S bit clock; the only clock. All logic is on posedge.
- reset_n  in  1  — asynchronous, active-low reset.
- enable  in  1  — run the frame counter and capture.
- i2s_data  in  1  — serial data from the microphone.
- i2s_ws  out  1  — word select. 0 = left slot, 1 = right slot.
- sample_data  out  DATA_WIDTH  — FIFO head. Forced to 0 when sample_valid = 0.
- sample_valid  out  1  — FIFO not empty.
- sample_ready  in  1  — consumer accepts the head on a cycle where valid && ready.
- overflow  out  1  — sticky; a sample was dropped.
- clear_ovf  in  1  — synchronous clear of overflow.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  — occupied entries.

## Operation
- Frame counter cnt, range 0..2*SLOT_BITS-1, wraps to 0.
- i2s_ws = cnt ≥ SLOT_BITS, taken directly from the counter MSB so it is glitch-free.
- enable = 0:
  - cnt is held at 0 and i2s_ws stays 0.
  - No capture takes place.
  - A partially captured word is discarded.
  - FIFO pops continue normally.
- Capture (standard I2S one-bit delay):
  - On a posedge with enable = 1 and cnt in 1..DATA_WIDTH, shift = {shift[DATA_WIDTH-2:0], i2s_data}.
  - The MSB is sampled at cnt = 1 and the LSB at cnt = DATA_WIDTH.
  - The right slot is ignored (mono).
- Push: at the posedge where cnt = DATA_WIDTH, the completed word {shift[DATA_WIDTH-2:0], i2s_data} is written to the FIFO.
- FIFO:
  - First-word-fall-through; sample_valid = level ≠ 0.
  - Pop on valid && ready.
- Full FIFO:
  - Push without a pop in the same cycle: the new word is dropped, level stays FIFO_DEPTH, overflow is set.
  - Push and pop in the same cycle: both occur and level is unchanged.
- Empty FIFO: sample_ready is ignored.
- overflow:
  - Cleared by clear_ovf or reset.
  - A set in the same cycle as clear_ovf wins.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Level has one extra bit so that full is distinguishable from empty.

## Timing
- Reset values: cnt 0, i2s_ws 0, sample_valid 0, sample_data 0, fifo_level 0, overflow 0, shift 0. Reset mid-frame abandons the word.
- After reset release with enable = 1:
  - The first edge moves cnt 0→1.
  - i2s_ws rises after the edge that leaves cnt = SLOT_BITS.
- Push latency: sample_valid goes high after the same edge that samples the LSB (cnt = DATA_WIDTH). sample_data is valid in that cycle.
- Throughput: one sample per 2*SLOT_BITS clocks.
- enable deasserted:
  - Takes effect at the next edge: cnt → 0, shift retained but ignored.
  - On re-enable, counting starts from cnt = 0 and the next full left slot is captured.

## Structure
- Package i2s_pkg holds:
  - default DATA_WIDTH, SLOT_BITS, FIFO_DEPTH;
  - the ws polarity constant (LEFT = 0);
  - a level-width function.
- Sub-module i2s_sample_fifo: parameterised FWFT synchronous FIFO with push, pop, full, empty and level. Instantiated once.
- The counter, capture shifter and overflow flag live in i2s_rx_master.

## Test plan
- Reset then enable with the bench serial model sending 0xA5 in the left slot, MSB first:
  - sample_data = 0xA5 with valid after the edge at cnt = 8 of frame 0;
  - i2s_ws toggles every 16 clocks.
- Ramp 0x01..0x06 sent with sample_ready held low, FIFO_DEPTH 4:
  - 0x01..0x04 are buffered and level reaches 4;
  - 0x05 and 0x06 are dropped and overflow = 1;
  - pops then return 0x01..0x04 in order.
- FIFO full and sample_ready = 1 exactly on the push edge:
  - the pop and the push both occur and level stays 4;
  - the pushed word later appears in order;
  - overflow stays 0.
- enable dropped at cnt = 5 mid-capture and restored 10 clocks later:
  - no word is pushed for the broken slot;
  - the next slot's byte is captured correctly.
- reset_n asserted asynchronously mid-slot with 2 samples buffered:
  - all outputs are immediately at reset values and level = 0;
  - after release the first sample matches the stimulus.
- overflow set, then clear_ovf pulsed in the same cycle as a new drop:
  - overflow stays 1;
  - a later clear_ovf alone clears it.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults and helpers for the I2S master receiver and its sample FIFO.
package i2s_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SLOT_BITS  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LEVEL_FULL);
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/i2s_rx_master.sv
// Mono I2S master receiver: drives word select from a frame counter, captures the
// left slot MSB-first with the standard one-bit delay and queues samples.
module i2s_rx_master
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                               i2s_clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               i2s_data,
  output logic                               i2s_ws,
  output logic [DATA_WIDTH-1:0]              sample_data,
  output logic                               sample_valid,
  input  logic                               sample_ready,
  output logic                               overflow,
  input  logic                               clear_ovf,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam logic [CW-1:0] CNT_FIRST = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  in_left, capture, push, pop, drop;
  logic                  fifo_full, fifo_empty;

  assign in_left = (cnt_q[CW-1] == WS_LEFT);
  assign capture = enable && in_left && (cnt_q >= CNT_FIRST) && (cnt_q <= CNT_LAST);
  assign word    = {shift_q, i2s_data};
  assign push    = enable && (cnt_q == CNT_LAST);
  assign pop     = sample_valid && sample_ready;
  assign drop    = push && fifo_full && !pop;

  always_comb begin
    cnt_d   = enable ? cnt_q + 1'b1 : '0;
    shift_d = capture ? word[DATA_WIDTH-2:0] : shift_q;
    ovf_d   = ovf_q;
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i2s_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  i2s_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i2s_clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign i2s_ws       = cnt_q[CW-1];
  assign sample_valid = !fifo_empty;
  assign sample_data  = sample_valid ? head_data : '0;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Randomised bench for i2s_rx_master: a microphone model feeds words and a
// queue-based reference predicts every output on every cycle.
module tb_i2s_rx_master;

  localparam int DW = 8;
  localparam int SB = 16;
  localparam int FD = 4;

  logic         i2s_clk = 1'b0;
  logic         reset_n, enable, i2s_data, sample_ready, clear_ovf;
  logic         i2s_ws, sample_valid, overflow;
  logic [DW-1:0] sample_data;
  logic [2:0]   fifo_level;

  always #5 i2s_clk = ~i2s_clk;

  i2s_rx_master #(
    .DATA_WIDTH (DW),
    .SLOT_BITS  (SB),
    .FIFO_DEPTH (FD)
  ) dut (
    .i2s_clk      (i2s_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .i2s_data     (i2s_data),
    .i2s_ws       (i2s_ws),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .fifo_level   (fifo_level)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: position in frame, buffered samples, sticky flag, mic word.
  int            m_cnt = 0;
  bit [DW-1:0]   m_q[$];
  bit            m_ovf = 1'b0;
  bit [DW-1:0]   mic_word = '0;
  bit [DW-1:0]   want[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $display("FAIL %s timeout waiting, got=none exp=event t=%0t", tag, $time);
  endtask

  task automatic check_outputs();
    chk("valid", sample_valid, (m_q.size() != 0));
    chk("data",  sample_data,  (m_q.size() != 0) ? m_q[0] : '0);
    chk("level", fifo_level,   m_q.size());
    chk("ovf",   overflow,     m_ovf);
    chk("ws",    i2s_ws,       (m_cnt >= SB));
  endtask

  // The microphone presents bit (DW - n) of its word ahead of the edge at frame position n.
  task automatic drive_data();
    if (m_cnt == 1) mic_word = (want.size() != 0) ? want.pop_front() : DW'($urandom);
    if (m_cnt >= 1 && m_cnt <= DW) i2s_data = mic_word[DW - m_cnt];
    else                           i2s_data = 1'($urandom);
  endtask

  task automatic cycle();
    bit          drop;
    bit [DW-1:0] tmp;
    @(posedge i2s_clk);
    if (reset_n) begin
      drop = 1'b0;
      if (m_q.size() != 0 && sample_ready) tmp = m_q.pop_front();
      if (enable && m_cnt == DW) begin
        if (m_q.size() < FD) m_q.push_back(mic_word);
        else                 drop = 1'b1;
      end
      if (drop)           m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      m_cnt = enable ? (m_cnt + 1) % (2 * SB) : 0;
    end
    @(negedge i2s_clk);
    check_outputs();
    drive_data();
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 4 * SB && m_cnt != target; i++) cycle();
    if (m_cnt != target) timeout_fail("wait_cnt");
  endtask

  task automatic wait_level(input int target);
    for (int i = 0; i < 12 * SB * FD && m_q.size() != target; i++) cycle();
    if (m_q.size() != target) timeout_fail("wait_level");
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    #1 check_outputs();
    repeat (3) cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    sample_ready = 1'b0;
    clear_ovf    = 1'b0;
    i2s_data     = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;

    // 0xA5 in the first left slot after enabling.
    want.push_back(8'hA5);
    enable = 1'b1;
    repeat (9) cycle();
    chk("a5_first", sample_data, 8'hA5);
    repeat (40) cycle();
    sample_ready = 1'b1;
    repeat (40) cycle();

    // Ramp with consumer stalled: four buffered, two dropped.
    sample_ready = 1'b0;
    wait_cnt(0);
    for (int v = 1; v <= 6; v++) want.push_back(DW'(v));
    repeat (6 * 2 * SB) cycle();
    chk("ramp_ovf", overflow, 1'b1);
    chk("ramp_lvl", fifo_level, 3'd4);
    sample_ready = 1'b1;
    repeat (4) cycle();
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;

    // Full FIFO with a pop exactly on the push edge.
    sample_ready = 1'b0;
    wait_level(FD);
    wait_cnt(DW);
    sample_ready = 1'b1;
    cycle();
    sample_ready = 1'b0;
    chk("pp_level", fifo_level, 3'd4);
    chk("pp_ovf", overflow, 1'b0);
    sample_ready = 1'b1;
    repeat (8) cycle();

    // Enable dropped mid-capture, restored 10 clocks later.
    wait_cnt(5);
    enable = 1'b0;
    repeat (10) cycle();
    want.push_back(8'h5A);
    enable = 1'b1;
    repeat (9) cycle();
    chk("reen_data", sample_data, 8'h5A);
    repeat (40) cycle();

    // Asynchronous reset with two samples buffered.
    sample_ready = 1'b0;
    wait_level(2);
    repeat (5) cycle();
    async_reset();
    want.push_back(8'h3C);
    repeat (9) cycle();
    chk("post_rst", sample_data, 8'h3C);

    // Clear coinciding with a fresh drop keeps the flag; a lone clear releases it.
    wait_level(FD);
    wait_cnt(DW);
    cycle();
    wait_cnt(DW);
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;
    chk("ovf_hold", overflow, 1'b1);
    cycle();
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;
    chk("ovf_clr", overflow, 1'b0);

    // Random traffic: mostly-draining, then mostly-stalled consumer.
    for (int i = 0; i < 1500; i++) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      clear_ovf    = ($urandom_range(0, 30) == 0);
      enable       = ($urandom_range(0, 80) != 0);
      cycle();
    end
    for (int i = 0; i < 1500; i++) begin
      sample_ready = ($urandom_range(0, 5) == 0);
      clear_ovf    = ($urandom_range(0, 60) == 0);
      enable       = ($urandom_range(0, 100) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
